sev_seg_scan: RTL and testbench

Multiplexed driver for a DIGITS-wide common-anode seven-segment display. Each digit code is decoded to active-low segments: 0–9 are digits, 10 is "-", and 11–15 are blank. The block time-multiplexes the anodes with a programmable refresh divider and a ghost-suppression guard cycle. It adds frame-synchronous double buffering, per-digit decimal points and per-digit blinking. It sits between the counter/score logic and the board's anode/segment pins.

---
 rtl/sev_seg_if.sv | 23 ++
 rtl/sev_seg_scan.sv | 153 +++++++++++++++
 tb/tb_sev_seg_scan.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sev_seg_if.sv
// rtl/sev_seg_if.sv - load-side and pin-side signals of the seven-segment scanner
interface sev_seg_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] nums;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blink_mask;
    logic                load;
    logic [DIGITS-1:0]   an_out;
    logic [6:0]          seg_out;
    logic                dp_out;
    logic                frame_tick;

    modport master (
        output nums, dp_in, blink_mask, load,
        input  an_out, seg_out, dp_out, frame_tick
    );

    modport slave (
        input  nums, dp_in, blink_mask, load,
        output an_out, seg_out, dp_out, frame_tick
    );
endinterface

// File: rtl/sev_seg_scan.sv
// rtl/sev_seg_scan.sv - multiplexed common-anode 7-seg driver; SEV_SEG_LZB_EN enables leading-zero blanking
module sev_seg_scan #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic     clk,
    input  logic     rst_n,
    sev_seg_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [BLK_W-1:0]    blink_cnt;
    logic                phase;
    logic                frame_end;

    logic [4*DIGITS-1:0] pend_nums;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blink;
    logic [4*DIGITS-1:0] act_nums;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_blink;

    logic [3:0]          cur_code;
    logic [DIGITS-1:0]   lzb;
    logic [DIGITS-1:0]   an_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b1100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0001100;
            4'd10:   decode = 7'b1111110;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Slot counter, digit index and blink phase; the phase only moves on a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_end) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Double buffer: loads land in pending; active swaps in at the frame boundary, taking a coincident load directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_nums  <= {DIGITS{4'hF}};
            pend_dp    <= '0;
            pend_blink <= '0;
            act_nums   <= {DIGITS{4'hF}};
            act_dp     <= '0;
            act_blink  <= '0;
        end else begin
            if (bus.load) begin
                pend_nums  <= bus.nums;
                pend_dp    <= bus.dp_in;
                pend_blink <= bus.blink_mask;
            end
            if (frame_end) begin
                act_nums  <= bus.load ? bus.nums       : pend_nums;
                act_dp    <= bus.load ? bus.dp_in      : pend_dp;
                act_blink <= bus.load ? bus.blink_mask : pend_blink;
            end
        end
    end

    // Code of the digit currently being scanned
    always_comb begin
        cur_code = act_nums[4*int'(idx) +: 4];
    end

`ifdef SEV_SEG_LZB_EN
    // Leading zeros are blanked from the top digit down until a dash or nonzero digit; digit 0 always shows
    always_comb begin
        logic       run;
        logic [3:0] c;
        lzb = '0;
        run = 1'b1;
        c   = 4'd0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            c      = act_nums[4*k +: 4];
            lzb[k] = run && (c == 4'd0);
            run    = run && ((c == 4'd0) || (c >= 4'd11));
        end
    end
`else
    assign lzb = '0;
`endif

    // Next pin values: guard cycle and blinked-off slots keep everything dark
    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        if ((cnt != '0) && !(phase && act_blink[idx])) begin
            an_nxt[idx] = 1'b0;
            seg_nxt     = lzb[idx] ? 7'b1111111 : decode(cur_code);
            dp_nxt      = ~act_dp[idx];
        end
    end

    // Registered pins, one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an_out     <= '1;
            bus.seg_out    <= 7'b1111111;
            bus.dp_out     <= 1'b1;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an_out     <= an_nxt;
            bus.seg_out    <= seg_nxt;
            bus.dp_out     <= dp_nxt;
            bus.frame_tick <= frame_end;
        end
    end
endmodule

// File: tb/tb_sev_seg_scan.sv
// tb/tb_sev_seg_scan.sv - directed frame-by-frame bench for sev_seg_scan (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
module tb_sev_seg_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sev_seg_if #(.DIGITS(4)) bus ();

    sev_seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] D0 = 7'h01;
    localparam logic [6:0] D1 = 7'h4F;
    localparam logic [6:0] D2 = 7'h12;
    localparam logic [6:0] D3 = 7'h06;
    localparam logic [6:0] D4 = 7'h4C;
    localparam logic [6:0] D5 = 7'h24;
    localparam logic [6:0] D7 = 7'h0F;
    localparam logic [6:0] D9 = 7'h0C;
    localparam logic [6:0] DA = 7'h7E;
`ifdef SEV_SEG_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h01;
`endif

    localparam int N_EV = 9;
    int          ev_k    [N_EV] = '{3, 20, 22, 47, 50, 66, 120, 132, 146};
    logic [15:0] ev_nums [N_EV] = '{16'h1234, 16'h5678, 16'h9A00, 16'h0007, 16'h00A5,
                                    16'h0050, 16'hFFF5, 16'h8888, 16'h2222};
    logic [3:0]  ev_dp   [N_EV] = '{4'b0010, 4'b1111, 4'b0000, 4'b0000, 4'b0001,
                                    4'b0000, 4'b0010, 4'b1111, 4'b1111};
    logic [3:0]  ev_bl   [N_EV] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                                    4'b0001, 4'b0000, 4'b0000, 4'b0000};

    int ev_idx = 0;
    int k = -1;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        if (ev_idx < N_EV && ev_k[ev_idx] == k + 1) begin
            bus.nums       = ev_nums[ev_idx];
            bus.dp_in      = ev_dp[ev_idx];
            bus.blink_mask = ev_bl[ev_idx];
            bus.load       = 1'b1;
            ev_idx++;
        end else begin
            bus.load = 1'b0;
        end
        @(posedge clk);
        k++;
        #1;
    endtask

    // segs = {digit3, digit2, digit1, digit0}; offs marks digits blinked off this frame
    task automatic run_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] dps, input logic [3:0] offs);
        for (int c = 0; c < 16; c++) begin
            int          slot;
            logic        et;
            logic [12:0] exp_v;
            tick();
            slot = c / 4;
            et   = (c == 15);
            if (c % 4 == 0) begin
                check_eq($sformatf("%s guard c%0d", tag, c),
                         {bus.an_out, bus.seg_out, bus.dp_out, bus.frame_tick},
                         {4'hF, 7'h7F, 1'b1, et});
            end else if (offs[slot]) begin
                check_eq($sformatf("%s blink_off c%0d", tag, c),
                         {bus.an_out, bus.frame_tick}, {4'hF, et});
            end else begin
                exp_v = {~(4'b0001 << slot), segs[slot*7 +: 7], ~dps[slot], et};
                check_eq($sformatf("%s drive c%0d", tag, c),
                         {bus.an_out, bus.seg_out, bus.dp_out, bus.frame_tick}, exp_v);
            end
        end
    endtask

    initial begin
        bus.nums       = 16'h0;
        bus.dp_in      = 4'h0;
        bus.blink_mask = 4'h0;
        bus.load       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", {bus.an_out, bus.seg_out, bus.dp_out, bus.frame_tick},
                 {4'hF, 7'h7F, 1'b1, 1'b0});
        rst_n = 1'b1;

        run_frame("f0_blank",   {BL, BL, BL, BL}, 4'b0000, 4'b0000);
        run_frame("f1_1234",    {D1, D2, D3, D4}, 4'b0010, 4'b0000);
        run_frame("f2_9A00",    {D9, DA, D0, D0}, 4'b0000, 4'b0000);
        run_frame("f3_0007",    {LZ, LZ, LZ, D7}, 4'b0000, 4'b0000);
        run_frame("f4_00A5",    {LZ, LZ, DA, D5}, 4'b0001, 4'b0000);
        run_frame("f5_0050",    {LZ, LZ, D5, D0}, 4'b0000, 4'b0000);
        run_frame("f6_blink",   {LZ, LZ, D5, D0}, 4'b0000, 4'b0001);
        run_frame("f7_blink",   {LZ, LZ, D5, D0}, 4'b0000, 4'b0001);
        run_frame("f8_dp_only", {BL, BL, BL, D5}, 4'b0010, 4'b0000);

        repeat (3) tick();
        #3;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        #1;
        check_eq("async_reset", {bus.an_out, bus.seg_out, bus.dp_out, bus.frame_tick},
                 {4'hF, 7'h7F, 1'b1, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = -1;

        run_frame("r0_blank", {BL, BL, BL, BL}, 4'b0000, 4'b0000);
        run_frame("r1_blank", {BL, BL, BL, BL}, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
